procesador_multiciclo: RTL and testbench
========================================

Name: procesador_multiciclo

Overview:
- Multi-cycle RV32I core, the successor to the single-cycle processor.
- Reuses the existing control unit, register file, immediate generator, ALU, branch unit, instruction memory and data memory.
- Sequences each instruction through an explicit FSM with architectural holding registers (IR, A, B, ALUOut, MDR).
- Adds parametrised reset vector, data-memory wait states, an external stall input, a halt-on-SYSTEM state and retire reporting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_WAIT_CYCLES, 0, extra wait cycles spent in MEM before the data access completes (0..15)
WAIT_W, 4, width of the wait-state counter; must satisfy 2**WAIT_W > MEM_WAIT_CYCLES

Ports:
Clk  input  1  core clock, all state updates on rising edge
Rst  input  1  synchronous, active-high reset
Stall  input  1  when high in FETCH, holds the core in FETCH (no fetch, no PC change)
Out_PC  output  32  current architectural PC
State  output  3  FSM state encoding (debug)
Retire  output  1  one-cycle pulse in WB when an instruction commits
Retire_pc  output  32  PC of the committing instruction, valid while Retire=1
Halted  output  1  high while the FSM is in HALTED
Cycle_count  output  64  cycles since reset (see Optional Feature)
Instret_count  output  64  retired instructions since reset (see Optional Feature)

Behaviour:
- Reset (Rst high at a rising edge):
  - State=FETCH, Out_PC=RESET_PC, IR/A/B/ALUOut/MDR=0, wait counter=0.
  - Retire=0, Halted=0.
  - Register file contents are not reset.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALTED=5.
- FETCH:
  - Stall=1: remain in FETCH.
  - Otherwise IR<=instruction at Out_PC, go to DECODE.
- DECODE:
  - A<=rs1, B<=rs2; control signals decoded from IR.
  - Opcode 7'b1110011 (ECALL/EBREAK): go to HALTED, no retire.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - ALUOut<=ALU(muxA, muxB).
  - Taken<=branch unit NextPCSrc.
  - Load (7'b0000011) or store (7'b0100011): go to MEM, wait counter<=0.
  - Otherwise go to WB.
- MEM:
  - Address=ALUOut.
  - While counter<MEM_WAIT_CYCLES: counter increments, stay in MEM.
  - On the final MEM cycle only:
    - Store: DMWr asserted for exactly that cycle, data=B.
    - Load: MDR<=DataRd.
  - Then go to WB.
  - MEM duration = MEM_WAIT_CYCLES+1 cycles.
- WB:
  - Register write enabled only here, only when decoded RUWr=1.
  - Write-back source selects ALUOut / MDR / PC+4.
  - Writes to x0 are ignored.
  - Out_PC<=Taken ? ALUOut : Out_PC+4.
  - Retire=1, Retire_pc=old PC.
  - Go to FETCH.
- HALTED: absorbing; only Rst exits. Halted=1, PC frozen, no memory or register writes.
- Latency:
  - ALU, branch and jump instructions: 4 cycles.
  - Loads and stores: 5+MEM_WAIT_CYCLES cycles.
- Gating and interaction rules:
  - DMWr and register-file write are combinationally gated with !Rst.
  - Rst asserted during MEM or WB suppresses the pending store or register write.
  - Stall is ignored outside FETCH; an instruction in flight always completes.
- Arithmetic: PC+4 wraps modulo 2**32; JALR target LSB cleared before loading the PC.

Optional Feature:
- Macro PROCESADOR_PERF_CNT_EN.
- Defined:
  - Cycle_count increments every non-reset cycle, including stalled and HALTED cycles.
  - Instret_count increments on every Retire pulse.
  - Both counters are 64-bit, clear on Rst and wrap to 0 after all-ones.
- Undefined: both outputs are constant 0 and no counter flops exist. The ports remain present in both builds.

Test Plan:
- Rst, then `addi x1,x0,5`; `addi x2,x1,3` with MEM_WAIT_CYCLES=0 -> Retire pulses at cycles 4 and 8 after reset release; x2=8; Out_PC=8.
- MEM_WAIT_CYCLES=2: `sw x2,0(x0)` then `lw x3,0(x0)` -> DMWr high exactly 1 cycle, in the 3rd MEM cycle; each instruction takes 7 cycles; x3=8.
- `beq x1,x1,+16` at PC=0x10 -> Retire_pc=0x10, next Out_PC=0x20. The same with `bne` -> Out_PC=0x14.
- Stall held high for 5 cycles in FETCH -> State stays 0 and Out_PC is unchanged. Stall asserted mid-EXECUTE has no effect.
- `ebreak` at PC=0x0C -> Halted=1 two cycles after fetch, no Retire, Out_PC stays 0x0C. After Rst: Out_PC=RESET_PC, Halted=0.
- Rst asserted during the MEM final cycle of a store to 0x40 -> memory at 0x40 unchanged; State=FETCH next cycle. With PROCESADOR_PERF_CNT_EN: Cycle_count=0 and Instret_count=0 after that reset.

Source files
------------

// File: rtl/procesador_multiciclo.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB FSM over IR, A, B, ALUOut and MDR holding registers.
// Optional 64-bit cycle/instret counters are built when PROCESADOR_PERF_CNT_EN is defined.
module procesador_multiciclo #(
  parameter logic [31:0]              RESET_PC        = 32'h0000_0000,
  parameter int unsigned              MEM_WAIT_CYCLES = 0,
  parameter int unsigned              WAIT_W          = 4,
  parameter int unsigned              IMEM_WORDS      = 64,
  parameter int unsigned              DMEM_WORDS      = 64,
  parameter logic [IMEM_WORDS*32-1:0] PROGRAM         = '0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  output logic [31:0] Out_PC,
  output logic [2:0]  State,
  output logic        Retire,
  output logic [31:0] Retire_pc,
  output logic        Halted,
  output logic [63:0] Cycle_count,
  output logic [63:0] Instret_count
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_CYCLES);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC4} wb_src_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_out_q, alu_out_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              taken_q, taken_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [31:0] rf   [32];
  logic [31:0] dmem [DMEM_WORDS];

  // ---------------- control unit ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic       ru_wr, a_sel_pc, b_sel_imm;
  logic       is_load, is_store, is_branch, is_jal, is_jalr, is_system;
  alu_op_t    alu_op;
  wb_src_t    wb_src;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];

  always_comb begin
    ru_wr     = 1'b0;
    a_sel_pc  = 1'b0;
    b_sel_imm = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_system = 1'b0;
    alu_op    = ALU_ADD;
    wb_src    = WB_ALU;
    case (opcode)
      OP_R, OP_I: begin
        ru_wr     = 1'b1;
        b_sel_imm = (opcode == OP_I);
        case (funct3)
          3'b000:  alu_op = (opcode == OP_R && ir_q[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = ir_q[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        ru_wr = 1'b1; b_sel_imm = 1'b1; is_load = 1'b1; wb_src = WB_MDR;
      end
      OP_STORE:  begin b_sel_imm = 1'b1; is_store = 1'b1; end
      OP_BRANCH: begin a_sel_pc = 1'b1; b_sel_imm = 1'b1; is_branch = 1'b1; end
      OP_JAL: begin
        ru_wr = 1'b1; a_sel_pc = 1'b1; b_sel_imm = 1'b1; is_jal = 1'b1; wb_src = WB_PC4;
      end
      OP_JALR: begin
        ru_wr = 1'b1; b_sel_imm = 1'b1; is_jalr = 1'b1; wb_src = WB_PC4;
      end
      OP_LUI:    begin ru_wr = 1'b1; b_sel_imm = 1'b1; alu_op = ALU_PASSB; end
      OP_AUIPC:  begin ru_wr = 1'b1; a_sel_pc = 1'b1; b_sel_imm = 1'b1; end
      OP_SYSTEM: is_system = 1'b1;
      default: ;
    endcase
  end

  // ---------------- immediate generator ----------------
  logic [31:0] imm;
  always_comb begin
    case (opcode)
      OP_STORE:         imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:        imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {ir_q[31:12], 12'b0};
      OP_JAL:           imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:          imm = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // ---------------- ALU ----------------
  logic [31:0] alu_a, alu_b, alu_res;
  assign alu_a = a_sel_pc  ? pc_q : a_q;
  assign alu_b = b_sel_imm ? imm  : b_q;

  always_comb begin
    case (alu_op)
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_SLL:   alu_res = alu_a << alu_b[4:0];
      ALU_SLT:   alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {31'b0, alu_a < alu_b};
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SRL:   alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_res = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = alu_a + alu_b;
    endcase
  end

  // ---------------- branch unit ----------------
  logic br_cond, next_pc_src;
  always_comb begin
    case (funct3)
      3'b000:  br_cond = (a_q == b_q);
      3'b001:  br_cond = (a_q != b_q);
      3'b100:  br_cond = ($signed(a_q) <  $signed(b_q));
      3'b101:  br_cond = ($signed(a_q) >= $signed(b_q));
      3'b110:  br_cond = (a_q <  b_q);
      3'b111:  br_cond = (a_q >= b_q);
      default: br_cond = 1'b0;
    endcase
  end
  assign next_pc_src = is_jal | is_jalr | (is_branch & br_cond);

  // ---------------- memories ----------------
  logic [31:0]    imem_rdata;
  logic [DAW-1:0] dm_idx;
  logic [31:0]    dm_rdata, dm_wdata, ld_shift, ld_data;
  logic [3:0]     dm_be;
  logic           mem_last, dm_wr;

  assign imem_rdata = PROGRAM[{pc_q[IAW+1:2], 5'b00000} +: 32];
  assign dm_idx     = alu_out_q[DAW+1:2];
  assign dm_rdata   = dmem[dm_idx];
  assign ld_shift   = dm_rdata >> {alu_out_q[1:0], 3'b000};
  assign mem_last   = (wait_cnt_q == WAIT_LAST);
  assign dm_wr      = (state_q == S_MEM) && mem_last && is_store && !Rst;

  always_comb begin
    case (funct3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'b0, ld_shift[7:0]};
      3'b101:  ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = dm_rdata;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000: begin
        dm_be    = 4'b0001 << alu_out_q[1:0];
        dm_wdata = {4{b_q[7:0]}};
      end
      3'b001: begin
        dm_be    = alu_out_q[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{b_q[15:0]}};
      end
      default: begin
        dm_be    = 4'b1111;
        dm_wdata = b_q;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (dm_wr) begin
      for (int i = 0; i < 4; i++)
        if (dm_be[i]) dmem[dm_idx][i*8 +: 8] <= dm_wdata[i*8 +: 8];
    end
  end

  // ---------------- register file ----------------
  logic [31:0] rs1_data, rs2_data, wb_data, pc_plus4;
  logic        rf_we;

  assign pc_plus4 = pc_q + 32'd4;
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign rf_we    = (state_q == S_WB) && ru_wr && (rd != 5'd0) && !Rst;

  always_comb begin
    case (wb_src)
      WB_MDR:  wb_data = mdr_q;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_out_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rf_we) rf[rd] <= wb_data;
  end

  // ---------------- sequencing FSM ----------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_out_d  = alu_out_q;
    mdr_d      = mdr_q;
    taken_d    = taken_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (!Stall) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs1_data;
        b_d     = rs2_data;
        state_d = is_system ? S_HALTED : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_out_d = alu_res;
        taken_d   = next_pc_src;
        if (is_load || is_store) begin
          wait_cnt_d = '0;
          state_d    = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_last) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          if (is_load) mdr_d = ld_data;
          state_d = S_WB;
        end
      end
      S_WB: begin
        // JALR targets drop bit 0; other targets are already even.
        pc_d    = taken_q ? {alu_out_q[31:1], alu_out_q[0] & ~is_jalr} : pc_plus4;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_out_q  <= '0;
      mdr_q      <= '0;
      taken_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_out_q  <= alu_out_d;
      mdr_q      <= mdr_d;
      taken_q    <= taken_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign Out_PC    = pc_q;
  assign State     = state_q;
  assign Retire    = (state_q == S_WB);
  assign Retire_pc = pc_q;
  assign Halted    = (state_q == S_HALTED);

  // ---------------- performance counters ----------------
`ifdef PROCESADOR_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 64'd1;
    instret_cnt_d = instret_cnt_q;
    if (Retire) instret_cnt_d = instret_cnt_q + 64'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign Cycle_count   = cycle_cnt_q;
  assign Instret_count = instret_cnt_q;
`else
  assign Cycle_count   = 64'd0;
  assign Instret_count = 64'd0;
`endif

endmodule

// File: tb/tb_procesador_multiciclo.sv
// Directed bench for procesador_multiciclo with MEM_WAIT_CYCLES=2 and a fixed program in the ROM.
module tb_procesador_multiciclo;

  // 0x00 addi x1,x0,5    0x04 addi x2,x1,3    0x08 jal x0,+8      0x0C ebreak
  // 0x10 beq x1,x1,+16   0x14..0x1C addi x6,x0,1 (skipped)        0x20 bne x1,x1,+16
  // 0x24 sw x2,0(x0)     0x28 lw x3,0(x0)     0x2C sw x2,64(x0)   0x30 sw x1,64(x0)
  // 0x34 jal x0,-40 (-> 0x0C)
  localparam logic [64*32-1:0] PROG = {
    {(50*32){1'b0}},
    32'hFD9FF06F, 32'h04102023, 32'h04202023, 32'h00002183,
    32'h00202023, 32'h00109863, 32'h00100313, 32'h00100313,
    32'h00100313, 32'h00108863, 32'h00100073, 32'h0080006F,
    32'h00308113, 32'h00500093
  };

  logic        Clk, Rst, Stall;
  logic [31:0] Out_PC, Retire_pc;
  logic [2:0]  State;
  logic        Retire, Halted;
  logic [63:0] Cycle_count, Instret_count;

  int n_checks = 0;
  int n_fail   = 0;

  procesador_multiciclo #(
    .RESET_PC(32'h0000_0000),
    .MEM_WAIT_CYCLES(2),
    .WAIT_W(4),
    .IMEM_WORDS(64),
    .DMEM_WORDS(64),
    .PROGRAM(PROG)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall),
    .Out_PC(Out_PC), .State(State), .Retire(Retire), .Retire_pc(Retire_pc),
    .Halted(Halted), .Cycle_count(Cycle_count), .Instret_count(Instret_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int wr_cnt, wr_cyc;
    logic found;

    Rst = 1'b1; Stall = 1'b0;
    tick(); tick();
    Rst = 1'b0;

    // reset state, cycle 1 = FETCH of 0x00
    check("rst_state", State, 0);
    check("rst_pc", Out_PC, 0);
    check("rst_retire", Retire, 0);
    check("rst_halted", Halted, 0);
    check("rst_cycle", Cycle_count, 0);
    check("rst_instret", Instret_count, 0);

    // addi x1 retires in cycle 4, addi x2 in cycle 8
    repeat (3) tick();
    check("addi1_retire", {Retire, State}, {1'b1, 3'd4});
    check("addi1_rpc", Retire_pc, 32'h0);
    tick();
    check("addi1_pc", Out_PC, 32'h4);
    check("addi1_noret", Retire, 0);
    repeat (3) tick();
    check("addi2_retire", Retire, 1);
    check("addi2_rpc", Retire_pc, 32'h4);
    tick();
    check("addi2_pc", Out_PC, 32'h8);
    check("x1", dut.rf[1], 32'd5);
    check("x2", dut.rf[2], 32'd8);

    // Stall held in FETCH
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {State, Out_PC}, {3'd0, 32'h8});
    end
    Stall = 1'b0;

    // jal at 0x08; Stall raised in EXECUTE is ignored
    tick(); tick();
    check("jal_exec", State, 2);
    Stall = 1'b1;
    tick();
    check("jal_wb", {Retire, State}, {1'b1, 3'd4});
    check("jal_rpc", Retire_pc, 32'h8);
    Stall = 1'b0;
    tick();
    check("jal_pc", Out_PC, 32'h10);

    // beq taken at 0x10, bne not taken at 0x20
    repeat (3) tick();
    check("beq_rpc", {Retire, Retire_pc}, {1'b1, 32'h10});
    tick();
    check("beq_pc", Out_PC, 32'h20);
    repeat (4) tick();
    check("bne_pc", Out_PC, 32'h24);

    // sw x2,0(x0): 7 cycles, single write strobe in cycle 6 (third MEM cycle)
    wr_cnt = 0; wr_cyc = 0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (dut.dm_wr) begin wr_cnt++; wr_cyc = c; end
    end
    check("sw_wb", {Retire, State}, {1'b1, 3'd4});
    check("sw_wr_cnt", wr_cnt, 1);
    check("sw_wr_cyc", wr_cyc, 6);
    tick();
    check("sw_pc", Out_PC, 32'h28);
    check("sw_mem", dut.dmem[0], 32'd8);

    // lw x3,0(x0)
    repeat (6) tick();
    check("lw_wb", {Retire, Retire_pc}, {1'b1, 32'h28});
    tick();
    check("lw_pc", Out_PC, 32'h2C);
    check("x3", dut.rf[3], 32'd8);

    // sw x2,64(x0)
    repeat (7) tick();
    check("sw64_pc", Out_PC, 32'h30);
    check("sw64_mem", dut.dmem[16], 32'd8);
`ifdef PROCESADOR_PERF_CNT_EN
    check("perf_instret", Instret_count, 64'd8);
    check("perf_cycle", Cycle_count, 64'd46);
`else
    check("perf_instret_off", Instret_count, 64'd0);
    check("perf_cycle_off", Cycle_count, 64'd0);
`endif

    // sw x1,64(x0): reset lands on the final MEM cycle
    repeat (5) tick();
    check("abort_state", State, 3);
    check("abort_strobe_pre", dut.dm_wr, 1);
    Rst = 1'b1;
    #1;
    check("abort_strobe_gated", dut.dm_wr, 0);
    tick();
    Rst = 1'b0;
    check("abort_state_after", State, 0);
    check("abort_pc_after", Out_PC, 32'h0);
    check("abort_mem", dut.dmem[16], 32'd8);
    check("abort_cycle", Cycle_count, 0);
    check("abort_instret", Instret_count, 0);

    // second pass runs through to the ebreak at 0x0C
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (Out_PC == 32'h0C && State == 3'd0) found = 1'b1;
    end
    check("reach_ebreak", found, 1);
    check("pass2_mem", dut.dmem[16], 32'd5);
    tick();
    check("ebreak_decode", {Halted, Retire, State}, {1'b0, 1'b0, 3'd1});
    tick();
    check("ebreak_halted", {Halted, Retire, State}, {1'b1, 1'b0, 3'd5});
    repeat (3) tick();
    check("halted_hold", {Halted, Retire, Out_PC}, {1'b1, 1'b0, 32'h0C});

    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("unhalt", {Halted, State, Out_PC}, {1'b0, 3'd0, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
